// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction class and stall-reason encodings,
// plus the default producer latencies used by the multiplier, ID/EX and the
// hazard scoreboard.
package pipeline_pkg;

  typedef enum logic [1:0] {
    CLASS_ALU  = 2'b00,
    CLASS_LOAD = 2'b01,
    CLASS_MUL  = 2'b10,
    CLASS_RSVD = 2'b11   // decoded as ALU
  } idClass_e;

  typedef enum logic [1:0] {
    REASON_NONE = 2'b00,
    REASON_LOAD = 2'b01,
    REASON_MUL  = 2'b10,
    REASON_WAW  = 2'b11
  } stallReason_e;

  // Cycles after issue until a result becomes forwardable.
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MUL_LAT  = 4;
  // Countdown width; 2**DEF_CW must exceed DEF_MUL_LAT.
  localparam int DEF_CW       = 3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / stall-response bundle between decode and the hazard
// scoreboard. master = decode side, slave = scoreboard.
interface hazard_scoreboard_if;

  logic       ID_Valid;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic [4:0] ID_Rw;
  logic       ID_RegWrite;
  logic [1:0] ID_Class;
  logic       Freeze;
  logic       Flush;
  logic       Stall;
  logic [1:0] StallReason;
  logic       Busy;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Rw, ID_RegWrite,
           ID_Class, Freeze, Flush,
    input  Stall, StallReason, Busy
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Rw, ID_RegWrite,
           ID_Class, Freeze, Flush,
    output Stall, StallReason, Busy
  );

endinterface

// File: rtl/hazard_scoreboard_cnt_entry.sv
// One scoreboard entry: countdown of cycles until the in-flight result for
// this register is forwardable, plus the producer kind (0 load, 1 multiply).
module hazard_cnt_entry #(
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Freeze,
  input  logic          Load,
  input  logic [CW-1:0] LoadVal,
  input  logic          LoadCls,
  output logic [CW-1:0] Cnt,
  output logic          Cls
);

  // Countdown: issue load beats decrement; everything holds while frozen.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every entry sampling the same
    // pre-edge values, independent of process evaluation order.
    if (Reset) begin
      Cnt <= '0;
      Cls <= 1'b0;
    end else if (!Freeze) begin
      if (Load) begin
        Cnt <= LoadVal;
        Cls <= LoadCls;
      end else if (Cnt != '0) begin
        Cnt <= Cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side interlock beside ID: stalls decode on load-use, multiply RAW
// and multiply WAW hazards that the forwarding network cannot yet cover.
// Optional build macro HAZARD_PERF_CNT_EN adds StallCycles / LoadUseCycles.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int CW       = DEF_CW
) (
  input  logic                 CLK,
  input  logic                 Reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          StallCycles,
  output logic [31:0]          LoadUseCycles,
`endif
  hazard_scoreboard_if.slave   bus
);

  // Index 0 is hard-wired ready so lookups need no special case for $0.
  logic [CW-1:0] cntAll [0:31];
  logic          clsAll [0:31];
  logic [CW-1:0] newLat;
  logic          rawRs;
  logic          rawRt;
  logic          waw;
  logic          issue;

  assign cntAll[0] = '0;
  assign clsAll[0] = 1'b0;

  // NOTE: entries are ordinary flops with reset, not a RAM: Stall and Busy
  // read them combinationally and must be clean immediately after Reset.
  for (genvar r = 1; r < 32; r++) begin : g_entry
    hazard_cnt_entry #(.CW(CW)) u_entry (
      .CLK     (CLK),
      .Reset   (Reset),
      .Freeze  (bus.Freeze),
      .Load    (issue && (bus.ID_Rw == 5'(r))),
      .LoadVal (newLat),
      .LoadCls (bus.ID_Class == CLASS_MUL),
      .Cnt     (cntAll[r]),
      .Cls     (clsAll[r])
    );
  end

  // Latency of the instruction in ID; reserved class decodes as ALU.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    newLat = '0;
    case (bus.ID_Class)
      CLASS_LOAD: newLat = CW'(LOAD_LAT);
      CLASS_MUL:  newLat = CW'(MUL_LAT);
      default:    newLat = '0;
    endcase
  end

  assign rawRs = bus.ID_UsesRs && (bus.ID_Rs != 5'd0) && (cntAll[bus.ID_Rs] != '0);
  assign rawRt = bus.ID_UsesRt && (bus.ID_Rt != 5'd0) && (cntAll[bus.ID_Rt] != '0);
  assign waw   = bus.ID_RegWrite && (bus.ID_Rw != 5'd0) && (cntAll[bus.ID_Rw] > newLat);

  // Stall decision and reason; RAW outranks WAW, Rs outranks Rt.
  always_comb begin
    bus.Stall       = bus.ID_Valid && !bus.Flush && (rawRs || rawRt || waw);
    bus.StallReason = REASON_NONE;
    if (bus.Stall) begin
      if (rawRs)      bus.StallReason = clsAll[bus.ID_Rs] ? REASON_MUL : REASON_LOAD;
      else if (rawRt) bus.StallReason = clsAll[bus.ID_Rt] ? REASON_MUL : REASON_LOAD;
      else            bus.StallReason = REASON_WAW;
    end
  end

  assign issue = bus.ID_Valid && !bus.Stall && !bus.Flush && !bus.Freeze &&
                 bus.ID_RegWrite && (bus.ID_Rw != 5'd0);

  // Busy whenever any result is still in flight.
  always_comb begin
    bus.Busy = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cntAll[r] != '0) bus.Busy = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Stall-cycle statistics; frozen cycles are not attributed to hazards.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      StallCycles   <= '0;
      LoadUseCycles <= '0;
    end else if (bus.Stall && !bus.Freeze) begin
      StallCycles <= StallCycles + 32'd1;
      if (bus.StallReason == REASON_LOAD) LoadUseCycles <= LoadUseCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, all compared against a ready-time reference model.
module tb_hazard_scoreboard;
  import pipeline_pkg::*;

  localparam int LOAD_LAT = DEF_LOAD_LAT;
  localparam int MUL_LAT  = DEF_MUL_LAT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [31:0] loadUseCycles;
`endif

  hazard_scoreboard dut (
    .CLK           (clk),
    .Reset         (rst),
`ifdef HAZARD_PERF_CNT_EN
    .StallCycles   (stallCycles),
    .LoadUseCycles (loadUseCycles),
`endif
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an active-cycle clock plus the absolute active cycle at
  // which each register's result becomes forwardable.
  int tick = 0;
  int readyAt [32];
  bit isMul [32];
  int mStall = 0;
  int mLoadUse = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int remaining(input int r);
    int d;
    if (r == 0) return 0;
    d = readyAt[r] - tick;
    return (d > 0) ? d : 0;
  endfunction

  function automatic int latencyOf(input logic [1:0] cls);
    if (cls == CLASS_LOAD) return LOAD_LAT;
    if (cls == CLASS_MUL)  return MUL_LAT;
    return 0;
  endfunction

  // One clock: drive, check combinational outputs, then advance the model.
  task automatic stepCycle(input bit valid, input logic [4:0] rs, input logic [4:0] rt,
                           input bit uRs, input bit uRt, input logic [4:0] rw,
                           input bit rWr, input logic [1:0] cls, input bit frz,
                           input bit flush, input bit rs_t, output bit stallOut);
    bit rawRs, rawRt, waw, expStall, expBusy, doIssue;
    logic [1:0] expReason;
    int lat;
    @(negedge clk);
    bus.ID_Valid = valid; bus.ID_Rs = rs; bus.ID_Rt = rt;
    bus.ID_UsesRs = uRs; bus.ID_UsesRt = uRt; bus.ID_Rw = rw;
    bus.ID_RegWrite = rWr; bus.ID_Class = cls; bus.Freeze = frz;
    bus.Flush = flush; rst = rs_t;
    #1;
    lat      = latencyOf(cls);
    rawRs    = uRs && remaining(int'(rs)) > 0;
    rawRt    = uRt && remaining(int'(rt)) > 0;
    waw      = rWr && remaining(int'(rw)) > lat;
    expStall = valid && !flush && (rawRs || rawRt || waw);
    if (!expStall)  expReason = REASON_NONE;
    else if (rawRs) expReason = isMul[rs] ? REASON_MUL : REASON_LOAD;
    else if (rawRt) expReason = isMul[rt] ? REASON_MUL : REASON_LOAD;
    else            expReason = REASON_WAW;
    expBusy = 1'b0;
    for (int r = 1; r < 32; r++) if (remaining(r) > 0) expBusy = 1'b1;
    check("stall", bus.Stall, expStall);
    check("reason", bus.StallReason, expReason);
    check("busy", bus.Busy, expBusy);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", stallCycles, mStall);
    check("perf_loaduse", loadUseCycles, mLoadUse);
`endif
    stallOut = expStall;
    if (rs_t) begin
      for (int r = 0; r < 32; r++) begin readyAt[r] = 0; isMul[r] = 1'b0; end
      mStall = 0; mLoadUse = 0;
    end else if (!frz) begin
      if (expStall) mStall++;
      if (expStall && expReason == REASON_LOAD) mLoadUse++;
      doIssue = valid && !expStall && !flush && rWr && (rw != 5'd0);
      tick++;
      if (doIssue) begin
        readyAt[rw] = tick + lat;
        isMul[rw]   = (cls == CLASS_MUL);
      end
    end
  endtask

  task automatic idle(input bit rs_t);
    bit s;
    stepCycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, CLASS_ALU, 1'b0, 1'b0, rs_t, s);
  endtask

  task automatic issueOp(input logic [4:0] rw, input logic [1:0] cls);
    bit s;
    stepCycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rw, 1'b1, cls, 1'b0, 1'b0, 1'b0, s);
  endtask

  // Hold one instruction in ID until it issues; freezeMask bit i freezes cycle i.
  task automatic holdUntilIssue(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                                input bit uRs, input bit uRt, input logic [4:0] rw,
                                input bit rWr, input logic [1:0] cls,
                                input logic [31:0] freezeMask, output int stalls);
    bit s, done, frz;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      frz = freezeMask[i];
      stepCycle(1'b1, rs, rt, uRs, uRt, rw, rWr, cls, frz, 1'b0, 1'b0, s);
      if (s) stalls++;
      else if (!frz) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    bit s;
    for (int r = 0; r < 32; r++) begin readyAt[r] = 0; isMul[r] = 1'b0; end
    bus.ID_Valid = 1'b0; bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UsesRs = 1'b0;
    bus.ID_UsesRt = 1'b0; bus.ID_Rw = '0; bus.ID_RegWrite = 1'b0;
    bus.ID_Class = CLASS_ALU; bus.Freeze = 1'b0; bus.Flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", bus.Stall, 1'b0);
    check("rst_reason", bus.StallReason, REASON_NONE);
    check("rst_busy", bus.Busy, 1'b0);

    // Load-use: lw $5 then add $6,$5 -> one load-use stall.
    issueOp(5'd5, CLASS_LOAD);
    holdUntilIssue("loaduse", 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, CLASS_ALU, 32'd0, n);
    check("loaduse_cycles", n, 1);
    idle(1'b0);
    check("loaduse_busy", bus.Busy, 1'b0);

    // Multiply RAW via Rt -> four stall cycles.
    issueOp(5'd8, CLASS_MUL);
    holdUntilIssue("mulraw", 5'd0, 5'd8, 1'b0, 1'b1, 5'd7, 1'b1, CLASS_ALU, 32'd0, n);
    check("mulraw_cycles", n, 4);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_total", stallCycles, 32'd5);
    check("perf_lu_total", loadUseCycles, 32'd1);
`endif

    // Same, with two frozen cycles inside the stall window -> six.
    issueOp(5'd8, CLASS_MUL);
    holdUntilIssue("mulfrz", 5'd0, 5'd8, 1'b0, 1'b1, 5'd7, 1'b1, CLASS_ALU, 32'h6, n);
    check("mulfrz_cycles", n, 6);

    // WAW: mul $9 then add $9 with no sources.
    issueOp(5'd9, CLASS_MUL);
    holdUntilIssue("waw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, CLASS_ALU, 32'd0, n);
    check("waw_cycles", n, MUL_LAT);
    idle(1'b0);
    check("waw_busy", bus.Busy, 1'b0);

    // Register 0 is never tracked.
    issueOp(5'd0, CLASS_LOAD);
    holdUntilIssue("r0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, CLASS_ALU, 32'd0, n);
    check("r0_cycles", n, 0);

    // Flushed dependent: no stall, entry only decrements.
    issueOp(5'd3, CLASS_LOAD);
    stepCycle(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, CLASS_MUL, 1'b0, 1'b1, 1'b0, s);
    check("flush_stall", bus.Stall, 1'b0);
    holdUntilIssue("after_flush", 5'd3, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, CLASS_ALU, 32'd0, n);
    check("after_flush_cycles", n, 0);

    // Reset with a multiply in flight clears everything.
    issueOp(5'd10, CLASS_MUL);
    idle(1'b0);
    idle(1'b1);
    holdUntilIssue("post_rst", 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, CLASS_ALU, 32'd0, n);
    check("post_rst_cycles", n, 0);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      stepCycle(($urandom_range(0, 9) != 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 49) == 0), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side interlock for the 5-stage pipeline, complementing the forwarding unit. The forwarding unit resolves dependencies by bypass; this block detects when a bypass cannot yet supply the value and stalls decode.
- Tracks a per-register countdown of cycles until each in-flight result becomes forwardable.
- Asserts Stall for load-use, multi-cycle multiply RAW, and multiply WAW hazards.
- Sits beside the ID stage; Stall gates the PC/IF-ID write enables and injects a bubble into ID/EX.

Parameters:
- LOAD_LAT, 1, cycles after issue before a load result is forwardable (one bubble).
- MUL_LAT, 4, cycles after issue before a multiply result is forwardable.
- CW, 3, countdown width; must satisfy 2^CW > MUL_LAT.

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- ID_Valid  in  1  ID holds a real instruction
- ID_Rs  in  5  source register A
- ID_Rt  in  5  source register B
- ID_UsesRs  in  1  instruction reads Rs
- ID_UsesRt  in  1  instruction reads Rt (incl. store data)
- ID_Rw  in  5  destination register
- ID_RegWrite  in  1  instruction writes Rw
- ID_Class  in  2  00 ALU, 01 LOAD, 10 MUL, 11 reserved (treated as ALU)
- Freeze  in  1  global pipeline hold (e.g. memory wait); scoreboard holds state
- Flush  in  1  ID instruction squashed (branch taken); never issues
- Stall  out  1  hold IF/ID, bubble ID/EX (combinational)
- StallReason  out  2  00 none, 01 load-use, 10 MUL RAW, 11 WAW
- Busy  out  1  any countdown nonzero (registered-derived)

Behaviour:
- State: cnt[1..31], CW bits each; cnt[0] does not exist (register 0 is always ready). Each entry also carries a 1-bit cls (load vs mul) to select StallReason.
- Reset: all cnt = 0, cls = 0. Outputs after reset: Stall = 0, StallReason = 00, Busy = 0. Reset overrides every other input in the same cycle.
- RAW hazard: an operand is a hazard when it is used, its register is nonzero, and its cnt is nonzero. Checked for Rs (with ID_UsesRs) and Rt (with ID_UsesRt).
- WAW hazard: ID_RegWrite, Rw != 0, and cnt[Rw] > latency of the new instruction. ALU latency = 0.
- Stall = ID_Valid & !Flush & (RAW | WAW).
- StallReason priority: RAW beats WAW. For RAW, use cls of the Rs entry if Rs is the hazard, otherwise the Rt entry. Load maps to 01, mul to 10.
- Issue = ID_Valid & !Stall & !Flush & !Freeze & ID_RegWrite & (ID_Rw != 0).
- Per-cycle update when !Freeze:
  - every nonzero cnt decrements by 1;
  - on Issue, cnt[ID_Rw] is loaded with LOAD_LAT for a load, MUL_LAT for a multiply, or 0 for an ALU op, and cls is updated;
  - an issue load wins over the decrement of the same entry.
- Freeze = 1: no decrement and no issue. Stall is still computed combinationally.
- ALU producers never set a countdown; EX/MEM forwarding covers them.
- Load-use: a dependent instruction right after a load gets exactly LOAD_LAT stall cycles. A non-dependent instruction in between absorbs them.
- Flush with a hazard: Stall = 0 and nothing is recorded.
- Entries already in flight are not cleared by Flush; they belong to older, committed instructions.
- Busy = OR of all cnt != 0.

Optional Feature:
- HAZARD_PERF_CNT_EN
- Defined: adds outputs StallCycles (32) and LoadUseCycles (32), both cleared by Reset.
  - StallCycles counts cycles with Stall & !Freeze.
  - LoadUseCycles counts the subset with StallReason = 01.
  - Both wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - ID_Class encodings (CLASS_ALU, CLASS_LOAD, CLASS_MUL);
  - StallReason encodings;
  - default LOAD_LAT and MUL_LAT, shared with the multiplier and the ID/EX stage.
- One natural sub-module: hazard_cnt_entry, one per register (load/decrement/hold, cls bit), instantiated for registers 1..31 via generate.

Test Plan:
- Load-use: lw $5 issued; next instruction add reads $5 (UsesRs=1) -> Stall=1 and StallReason=01 for exactly 1 cycle, then Stall=0 and Busy=0.
- Multiply RAW: mul $8 issued (MUL_LAT=4); next instruction reads $8 via Rt -> Stall=1, StallReason=10 for 4 cycles. Add Freeze=1 for 2 of those cycles -> total stall cycles become 6.
- WAW: mul $9, then add $9 with no source dependency -> Stall=1, StallReason=11 until cnt[9]=0, then the add issues and cnt[9] stays 0.
- Register 0 and Flush: lw $0 followed by a use of $0 -> no stall. lw $3 followed by a dependent instruction with Flush=1 -> Stall=0 and cnt unchanged apart from the decrement.
- Reset mid-operation: mul $10 in flight (cnt=3), Reset=1 for one cycle -> next cycle all cnt=0, Busy=0, and a dependent reader is not stalled.
- Perf counters (HAZARD_PERF_CNT_EN): run the load-use and multiply scenarios back to back -> StallCycles=5, LoadUseCycles=1.
